// File: rtl/dcnt_seq.sv
`default_nettype none
// dcnt_seq -- sequencer for a cascaded preset/count down-counter chain (rev 1.0)
// Drives chain preset-load and carry-in; adds prescaler, one-shot/periodic modes, irq/ovf.
module dcnt_seq #(
  parameter int PW = 8
) (
  input  logic          MasterClock,
  input  logic          RESETL,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [PW-1:0] prescale,
  input  logic          tc_in,
  input  logic          irq_ack,
  output logic          prl_n,
  output logic          ci,
  output logic          run,
  output logic          irq,
  output logic          ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_cnt_q, presc_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          irq_q, irq_d;
  logic          ovf_q, ovf_d;
  logic          w_ci;
  logic          w_tc;

  // Carry-in and the terminal-count sample are decoded purely from registers.
  assign w_ci = (state_q == S_RUN) && (presc_cnt_q == presc_q);
  assign w_tc = w_ci && tc_in;

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      state_q     <= S_IDLE;
      presc_cnt_q <= '0;
      presc_q     <= '0;
      irq_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_cnt_q <= presc_cnt_d;
      presc_q     <= presc_d;
      irq_q       <= irq_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    presc_cnt_d = presc_cnt_q;
    presc_d     = presc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        presc_d     = prescale;
        presc_cnt_d = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        presc_cnt_d = w_ci ? '0 : presc_cnt_q + PW'(1);
        if (stop)                    state_d = S_IDLE;
        else if (start)              state_d = S_LOAD;
        else if (w_tc && !periodic)  state_d = S_DONE;
      end
      S_DONE: begin
        if (stop)       state_d = S_IDLE;
        else if (start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A terminal count coinciding with an acknowledge re-raises irq but is not an overflow.
  always_comb begin
    irq_d = irq_q;
    ovf_d = ovf_q;
    if (irq_ack) begin
      irq_d = w_tc;
      ovf_d = 1'b0;
    end else if (w_tc) begin
      if (irq_q) ovf_d = 1'b1;
      else       irq_d = 1'b1;
    end
  end

  assign prl_n = (state_q != S_LOAD);
  assign ci    = w_ci;
  assign run   = (state_q == S_RUN);
  assign irq   = irq_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dcnt_seq.sv
`default_nettype none
// tb_dcnt_seq -- scoreboard bench for dcnt_seq with a 4-bit chain model (rev 1.0)
module tb_dcnt_seq;
  localparam int PW = 8;
  localparam int N  = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

  logic          MasterClock = 1'b0;
  logic          RESETL = 1'b0;
  logic          start = 1'b0, stop = 1'b0, periodic = 1'b0, irq_ack = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic          tc_in;
  logic          prl_n, ci, run, irq, ovf;
  logic          noise = 1'b0;
  logic [N-1:0]  chain_q;

  dcnt_seq #(.PW(PW)) dut (
    .MasterClock(MasterClock), .RESETL(RESETL), .start(start), .stop(stop),
    .periodic(periodic), .prescale(prescale), .tc_in(tc_in), .irq_ack(irq_ack),
    .prl_n(prl_n), .ci(ci), .run(run), .irq(irq), .ovf(ovf)
  );

  always #5 MasterClock = ~MasterClock;

  // External down-counter chain; noise injects tc_in pulses while ci is low.
  always @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL)     chain_q <= '1;
    else if (!prl_n) chain_q <= '1;
    else if (ci)     chain_q <= chain_q - N'(1);
  end
  assign tc_in = (ci && chain_q == '0) || (noise && !ci);

  int   vectors = 0, miscompares = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_exp, mon_act;

  int m_mode = M_IDLE, m_e = 0, m_p = 0;
  bit m_irq = 0, m_ovf = 0;

  function automatic bit m_ci();
    return (m_mode == M_RUN) && ((m_e % (m_p + 1)) == m_p);
  endfunction

  // Terminal count is the 16th carry-in pulse since the chain was preset.
  function automatic bit m_tc();
    return m_ci() && (((m_e / (m_p + 1)) % (1 << N)) == ((1 << N) - 1));
  endfunction

  function automatic logic [4:0] m_out();
    return {m_mode != M_LOAD, m_ci(), m_mode == M_RUN, m_irq, m_ovf};
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE; m_e = 0; m_p = 0; m_irq = 0; m_ovf = 0;
  endtask

  task automatic step(input bit s, input bit sp, input bit per, input int pre,
                      input bit ack, input bit nz);
    bit tcs;
    @(negedge MasterClock);
    vectors++;
    if ((ci && chain_q == '0) !== m_tc()) begin
      miscompares++;
      $display("FAIL tc t=%0t chain_tc=%b model_tc=%b", $time, (ci && chain_q == '0), m_tc());
    end
    start = s; stop = sp; periodic = per; prescale = pre[PW-1:0]; irq_ack = ack; noise = nz;
    tcs = m_tc();
    if (ack) begin
      m_irq = tcs; m_ovf = 0;
    end else if (tcs) begin
      if (m_irq) m_ovf = 1;
      else       m_irq = 1;
    end
    case (m_mode)
      M_IDLE: if (s) m_mode = M_LOAD;
      M_LOAD: begin m_mode = M_RUN; m_p = pre; m_e = 0; end
      M_RUN: begin
        if (sp)              m_mode = M_IDLE;
        else if (s)          m_mode = M_LOAD;
        else if (tcs && !per) m_mode = M_DONE;
        else                 m_e++;
      end
      default: begin
        if (sp)     m_mode = M_IDLE;
        else if (s) m_mode = M_LOAD;
      end
    endcase
    exp_q.push_back(m_out());
  endtask

  task automatic idle(input int n, input bit per, input int pre);
    for (int i = 0; i < n; i++) step(0, 0, per, pre, 0, 0);
  endtask

  task automatic check_reset(input string name);
    vectors++;
    if ({prl_n, ci, run, irq, ovf} !== 5'b10000) begin
      miscompares++;
      $display("FAIL %s prl_n,ci,run,irq,ovf act=%b exp=10000", name, {prl_n, ci, run, irq, ovf});
    end
  endtask

  task automatic check_chain(input string name, input logic [N-1:0] exp);
    @(posedge MasterClock); #2;
    vectors++;
    if (chain_q !== exp) begin
      miscompares++;
      $display("FAIL %s chain act=%b exp=%b", name, chain_q, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge MasterClock); #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {prl_n, ci, run, irq, ovf};
        vectors++;
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL outs t=%0t prl_n,ci,run,irq,ovf act=%b exp=%b", $time, mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #23 check_reset("reset_hold");
    @(negedge MasterClock) RESETL = 1'b1;
    m_reset();

    // Basic one-shot count, prescale 0.
    step(1, 0, 0, 0, 0, 0);
    idle(22, 0, 0);
    check_chain("done_chain", 4'b1111);
    step(0, 0, 0, 0, 1, 0);

    // Prescaled periodic, no ack (ovf), mid-run prescale change ignored.
    step(1, 0, 1, 2, 0, 0);
    idle(40, 1, 2);
    idle(60, 1, 5);
    step(0, 1, 1, 2, 0, 0);
    step(0, 0, 1, 2, 1, 0);

    // Same, acknowledged at k+60.
    step(1, 0, 1, 2, 0, 0);
    for (int i = 1; i < 100; i++) step(0, 0, 1, 2, i == 60, 0);
    step(0, 1, 1, 2, 1, 0);
    step(0, 0, 1, 2, 1, 0);

    // Ack colliding with every sampled terminal count.
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0, m_tc(), 0);
    step(0, 1, 1, 0, 1, 0);

    // Stop / restart.
    step(1, 0, 0, 0, 0, 0);
    idle(4, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check_chain("stop_chain", 4'b1011);
    idle(3, 0, 0);
    check_chain("frozen_chain", 4'b1011);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(2, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_chain("restart_chain", 4'b1111);
    idle(3, 0, 0);

    // Randomised operation with spurious tc_in while ci is low.
    for (int i = 0; i < 2500; i++)
      step($urandom % 60 == 0, $urandom % 90 == 0, $urandom % 4 != 0,
           int'($urandom % 4), $urandom % 25 == 0, $urandom % 8 == 0);

    // Async reset mid-RUN with irq pending.
    step(0, 1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    idle(20, 1, 0);
    @(negedge MasterClock);
    start = 0; stop = 0; irq_ack = 0; noise = 0; periodic = 0; prescale = '0;
    #2 RESETL = 1'b0;
    #1 check_reset("async_reset");
    m_reset();
    @(negedge MasterClock) RESETL = 1'b1;
    step(1, 0, 0, 1, 0, 0);
    idle(40, 0, 1);

    @(posedge MasterClock); #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending act=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dcnt_seq.md
Name: dcnt_seq

Overview:
Sequencer for an external synchronous down-counter chain built from cascaded preset/count bit cells.
- Chain convention: preset loads all-ones; counting toggles on carry-in; the top-cell carry-out is high when carry-in is high and the count is zero.
- The block drives the chain's preset-load (active-low) and carry-in, and adds a programmable prescaler, one-shot/periodic modes, and an interrupt request with acknowledge and overflow.
- Used as the timer controller beside the counter chain. Both the block and the chain are clocked on MasterClock.

Parameters:
PW, 8, prescaler width in bits; the carry-in pulse rate is 1/(prescale+1) of MasterClock.

Ports:
MasterClock  in  1  sole clock, rising edge
RESETL  in  1  asynchronous active-low reset
start  in  1  one-cycle request: preset chain, then run
stop  in  1  one-cycle request: halt counting
periodic  in  1  1 = continuous wrap, 0 = one-shot; sampled every cycle
prescale  in  PW  divider minus one; sampled only in LOAD
tc_in  in  1  carry-out of the top chain cell
irq_ack  in  1  one-cycle acknowledge; clears irq and ovf
prl_n  out  1  chain preset-load, active low
ci  out  1  chain carry-in (count enable)
run  out  1  high in RUN
irq  out  1  sticky terminal-count request
ovf  out  1  terminal count arrived while irq was still pending

Behaviour:
- Reset (asynchronous): state IDLE, presc_cnt 0, latched prescale 0, prl_n 1, ci 0, run 0, irq 0, ovf 0. Reset during any state aborts immediately.
- All outputs are decoded from registers only; there is no combinational input-to-output path.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start -> LOAD.
  - stop is ignored.
- LOAD (exactly one cycle):
  - prl_n = 0, ci = 0.
  - Latch prescale; clear presc_cnt.
  - -> RUN unconditionally.
  - The chain holds all-ones after this edge.
- RUN:
  - run = 1.
  - ci = 1 in a cycle exactly when presc_cnt == latched prescale; prescale 0 gives ci every cycle.
  - presc_cnt increments each cycle and wraps to 0 in the cycle following ci.
  - Priority: stop > start > terminal count.
  - stop -> IDLE; ci is 0 from the next cycle.
  - start -> LOAD (restart).
  - tc_in sampled 1 with periodic = 1: stay in RUN. The chain wraps to all-ones by itself.
  - tc_in sampled 1 with periodic = 0: -> DONE.
- DONE:
  - ci = 0, run = 0.
  - start -> LOAD.
  - stop -> IDLE.
- Interrupt logic (independent of the state transition taken):
  - tc_in is sampled only when ci = 1 in RUN; it is ignored otherwise.
  - On a sampled tc: if irq = 0, irq <= 1; else ovf <= 1.
  - irq_ack clears irq and ovf at the next edge.
  - irq_ack and a sampled tc in the same cycle: irq = 1, ovf = 0 (the set wins for irq; the event is not an overflow).
  - start or stop in the same cycle as a sampled tc: irq/ovf are still updated.
  - irq and ovf persist across stop and restart; only irq_ack or reset clears them.
- Period: for an N-bit chain, 2^N carry-in pulses between successive terminal counts, i.e. 2^N*(prescale+1) MasterClock cycles.
- Latency from the start-sampling edge k (prescale p, N-bit chain):
  - LOAD during k..k+1; RUN from edge k+1.
  - First ci in the cycle after edge k+1+p.
  - First tc in the cycle after edge k+2^N*(p+1).
  - irq rises at edge k+2^N*(p+1)+1.
- Changing prescale mid-RUN has no effect until the next LOAD.

Test Plan:
1. Reset values: hold RESETL low, then release -> prl_n=1, ci=0, run=0, irq=0, ovf=0; state IDLE.
2. Basic count: N=4 chain, prescale=0, periodic=0, start at edge k.
   - prl_n=0 only in cycle k..k+1.
   - ci high for 16 consecutive cycles.
   - irq=1 at edge k+17; state DONE; ci=0 afterwards; chain reads 1111.
3. Prescaled periodic: prescale=2, periodic=1, start at edge k.
   - irq at edge k+49.
   - With no ack, ovf=1 at edge k+97.
   - Ack at k+60 instead -> irq=0 and ovf=0 at k+61; irq rises again at edge k+97.
4. Ack collision: assert irq_ack in the same cycle tc_in is sampled -> irq=1, ovf=0.
5. Stop/restart:
   - stop at RUN cycle 5 -> IDLE next edge, ci=0, chain frozen at 1011.
   - start with stop in the same cycle in RUN -> IDLE, no LOAD.
   - start alone in RUN -> LOAD pulse, chain back to 1111.
6. Async reset mid-RUN with irq=1 -> all outputs take their reset values immediately, without a clock edge.
